// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, grant
// encoding and the latency counter width.
package mem_arb_pkg;

  localparam int WORD_SIZE = 16;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side request ports and memory-side bus of the arbiter, bundled together.
// The arbiter uses the slave view; the CPU/memory environment the master view.
interface mem_arbiter_if import mem_arb_pkg::*; ();

  logic                 i_req;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_data;
  logic                 i_ready;

  logic                 d_req_read;
  logic                 d_req_write;
  logic [WORD_SIZE-1:0] d_address;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_ready;

  logic                 mem_read;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_address;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;

  logic                 busy;

  modport slave (
    input  i_req, i_address, d_req_read, d_req_write, d_address, d_wdata, mem_rdata,
    output i_data, i_ready, d_rdata, d_ready,
           mem_read, mem_write, mem_address, mem_wdata, busy
  );

  modport master (
    output i_req, i_address, d_req_read, d_req_write, d_address, d_wdata, mem_rdata,
    input  i_data, i_ready, d_rdata, d_ready,
           mem_read, mem_write, mem_address, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arbiter_priority.sv
// Fixed-priority arbitration with alternation: data port wins unless it
// was the last one granted and the fetch port is also eligible.
module arb_priority import mem_arb_pkg::*; (
  input  logic   elig_i_i,
  input  logic   elig_d_i,
  input  grant_e last_grant_i,
  output logic   grant_valid_o,
  output grant_e grant_sel_o
);

  always_comb begin
    grant_valid_o = elig_i_i | elig_d_i;
    grant_sel_o   = GNT_D;
    if (elig_i_i && elig_d_i) begin
      grant_sel_o = (last_grant_i == GNT_D) ? GNT_I : GNT_D;
    end else if (elig_i_i) begin
      grant_sel_o = GNT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-ported memory between the fetch port and
// the data port; each access holds the memory for MEM_LATENCY cycles.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int MEM_LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  grant_e               last_grant_q;
  logic [WORD_SIZE-1:0] addr_q, wdata_q, i_data_q, d_rdata_q;
  logic                 wr_q, i_ready_q, d_ready_q;

  logic   elig_i, elig_d, grant_valid, in_busy, done;
  grant_e grant_sel;

  // A port whose ready is high this cycle is finishing; keep it from being re-granted.
  assign elig_i  = bus.i_req & ~i_ready_q;
  assign elig_d  = (bus.d_req_read | bus.d_req_write) & ~d_ready_q;
  assign in_busy = (state_q != ST_IDLE);
  assign done    = in_busy && (cnt_q == '0);

  arb_priority u_prio (
    .elig_i_i      (elig_i),
    .elig_d_i      (elig_d),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_sel_o   (grant_sel)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d = (grant_sel == GNT_D) ? ST_BUSY_D : ST_BUSY_I;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= GNT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      i_data_q     <= '0;
      d_rdata_q    <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      i_ready_q <= done && (state_q == ST_BUSY_I);
      d_ready_q <= done && (state_q == ST_BUSY_D);
      if (state_q == ST_IDLE && grant_valid) begin
        last_grant_q <= grant_sel;
        if (grant_sel == GNT_D) begin
          addr_q  <= bus.d_address;
          wdata_q <= bus.d_wdata;
          wr_q    <= bus.d_req_write;
        end else begin
          addr_q  <= bus.i_address;
          wr_q    <= 1'b0;
        end
      end
      if (done && !wr_q) begin
        if (state_q == ST_BUSY_I) i_data_q  <= bus.mem_rdata;
        else                      d_rdata_q <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    bus.busy        = in_busy;
    bus.mem_read    = in_busy & ~wr_q;
    bus.mem_write   = in_busy & wr_q;
    bus.mem_address = addr_q;
    bus.mem_wdata   = wdata_q;
    bus.i_data      = i_data_q;
    bus.d_rdata     = d_rdata_q;
    bus.i_ready     = i_ready_q;
    bus.d_ready     = d_ready_q;
  end

endmodule
